lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit controller between the CPU MEM stage and the data-memory port. It accepts one load/store per request and drives a word-aligned memory request with byte strobes. It holds the CPU stalled until the memory acknowledges, then returns the byte-lane-shifted, sign/zero-extended load result. A watchdog counter converts a missing acknowledge into a bus-error pulse.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in ACCESS without mem_ack before ERR (legal range 1..1023; counter is 10 bits)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
lsu_req  input  1  MEM stage holds a load/store; held high until the cycle stall drops
lsu_we  input  1  1 = store, 0 = load
lsu_func3  input  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
lsu_addr  input  32  byte address
lsu_wdata  input  32  store data (rs2)
lsu_stall  output  1  freeze pipeline
lsu_rdata  output  32  extended load data, valid while lsu_done=1
lsu_done  output  1  one-cycle completion pulse
lsu_err  output  1  one-cycle error pulse (timeout or misalign)
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  write request
mem_wstrb  output  4  byte write strobes, 0000 for loads
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completes the access this cycle
mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low. Reset puts the FSM in IDLE and clears all registered outputs and the watchdog. If reset asserts mid-access, mem_req drops immediately.
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE with lsu_req=1: latch we, func3, addr and wdata, clear the watchdog, then go to ACCESS. With MISALIGN_TRAP_EN and a misaligned request, go to ERR instead.
- ACCESS: mem_req=1 with stable address, strobes and data. The watchdog increments each cycle.
  - mem_ack=1: capture the result and go to DONE.
  - watchdog reaches TIMEOUT_CYCLES-1 with no ack: go to ERR.
  - mem_ack and timeout in the same cycle: ack wins.
- DONE: lsu_done=1 and lsu_rdata valid, then go to IDLE.
- ERR: lsu_err=1, lsu_rdata=0, no register write, then go to IDLE.
- lsu_stall is combinational: lsu_req & (state==IDLE | state==ACCESS). Stall drops in DONE/ERR so the held instruction retires. lsu_req seen in DONE/ERR is that same instruction, never a new one.
- mem_ack outside ACCESS is ignored.
- Minimum latency is 3 cycles: request, ACCESS with ack, DONE. In general it is N+2, where N is the number of ACCESS cycles.
- Store strobes:
  - sb: 0001 << addr[1:0], data {4{wdata[7:0]}}.
  - sh: 0011 << {addr[1],0}, data {2{wdata[15:0]}}.
  - sw: 1111, data wdata.
  - Other store func3: strobes 0000, still completes.
- Load: shift mem_rdata right by 8*addr[1:0], then extend by func3.
  - lb/lh: sign-extend bit 7/15.
  - lw: pass through.
  - lbu/lhu: zero-extend.
  - Any other func3: 0.
- Loads drive mem_wstrb=0000 and mem_we=0.
- Misaligned means: h/hu/sh with addr[0]=1, or w/sw with addr[1:0]!=0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned request goes IDLE -> ERR without asserting mem_req. Total 2 cycles, lsu_err pulses.
- Undefined: low address bits are forced to natural alignment (h: addr[0]=0; w: addr[1:0]=0) and the access proceeds normally.

Test Plan:
- Load lb, addr 0x0000_1003, mem_rdata 0x80_12_34_56, ack in the 1st ACCESS cycle -> mem_addr 0x1000, wstrb 0000, lsu_done on cycle 3, lsu_rdata 0xFFFF_FF80. Same with lbu -> 0x0000_0080.
- Store sh, addr 0x2002, wdata 0x1234_ABCD, ack after 4 cycles -> mem_wstrb 1100, mem_wdata 0xABCD_ABCD, stall high 5 cycles, done pulse, no err.
- Load lw with mem_ack never asserted, TIMEOUT_CYCLES=8 -> mem_req high exactly 8 cycles, then lsu_err one cycle, lsu_rdata 0, stall released.
- lw at addr 0x3001 -> with MISALIGN_TRAP_EN: no mem_req, err at cycle 2. Without: mem_addr 0x3000, normal done.
- Assert rst_n=0 during ACCESS of sw 0x4000 -> mem_req and lsu_stall low in the same cycle, FSM IDLE. After release, a new lhu at 0x4002 with rdata 0xBEEF_0000 returns 0x0000_BEEF.
- mem_ack pulsed while IDLE, then a lh at 0x5000 -> the stray ack is ignored. The request completes only on its own ack, with sign-extended 0x8001 -> 0xFFFF_8001.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: CPU MEM stage to data-memory port, with watchdog timeout.
// Optional build macro MISALIGN_TRAP_EN traps misaligned requests instead of aligning them.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_func3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_ERR} state_t;

  localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_func3;
  logic [1:0]  r_lane;
  logic [9:0]  r_wdog;

  logic        w_is_half;
  logic        w_is_word;
  logic [31:0] w_addr_al;

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'b000:  store_strb = 4'b0001 << lane;
      3'b001:  store_strb = 4'b0011 << {lane[1], 1'b0};
      3'b010:  store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  store_data = {4{wd[7:0]}};
      3'b001:  store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b010:  load_extend = sh;
      3'b100:  load_extend = {24'b0, sh[7:0]};
      3'b101:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = 32'b0;
    endcase
  endfunction

  // hu (101) only exists as a load; a store with 101 is simply an unsupported store
  assign w_is_half = (lsu_func3 == 3'b001) || ((lsu_func3 == 3'b101) && !lsu_we);
  assign w_is_word = (lsu_func3 == 3'b010);

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = (w_is_half && lsu_addr[0]) || (w_is_word && (lsu_addr[1:0] != 2'b00));
  assign w_addr_al  = lsu_addr;
`else
  assign w_addr_al = {lsu_addr[31:2],
                      lsu_addr[1] & ~w_is_word,
                      lsu_addr[0] & ~w_is_word & ~w_is_half};
`endif

  assign lsu_stall = lsu_req & ((r_state == S_IDLE) | (r_state == S_ACCESS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_func3   <= 3'b000;
      r_lane    <= 2'b00;
      r_wdog    <= 10'd0;
      lsu_rdata <= 32'b0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= 4'b0000;
      mem_addr  <= 32'b0;
      mem_wdata <= 32'b0;
    end else begin
      lsu_done <= 1'b0;
      lsu_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsu_req) begin
            r_we      <= lsu_we;
            r_func3   <= lsu_func3;
            r_lane    <= w_addr_al[1:0];
            r_wdog    <= 10'd0;
            mem_we    <= lsu_we;
            mem_addr  <= {w_addr_al[31:2], 2'b00};
            mem_wstrb <= lsu_we ? store_strb(lsu_func3, w_addr_al[1:0]) : 4'b0000;
            mem_wdata <= store_data(lsu_func3, lsu_wdata);
`ifdef MISALIGN_TRAP_EN
            if (w_misalign) begin
              lsu_err   <= 1'b1;
              lsu_rdata <= 32'b0;
              r_state   <= S_ERR;
            end else begin
              mem_req <= 1'b1;
              r_state <= S_ACCESS;
            end
`else
            mem_req <= 1'b1;
            r_state <= S_ACCESS;
`endif
          end
        end
        // ack has priority over a timeout expiring in the same cycle
        S_ACCESS: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            lsu_done  <= 1'b1;
            lsu_rdata <= r_we ? 32'b0 : load_extend(r_func3, r_lane, mem_rdata);
            r_state   <= S_DONE;
          end else if (r_wdog == WDOG_LAST) begin
            mem_req   <= 1'b0;
            lsu_err   <= 1'b1;
            lsu_rdata <= 32'b0;
            r_state   <= S_ERR;
          end else begin
            r_wdog <= r_wdog + 10'd1;
          end
        end
        S_DONE, S_ERR: begin
          lsu_rdata <= 32'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: driver pushes expected memory requests and responses, monitor checks them.
module tb_lsu_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_func3 = 3'b000;
  logic [31:0] lsu_addr = 32'b0;
  logic [31:0] lsu_wdata = 32'b0;
  logic        lsu_stall;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'b0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_func3(lsu_func3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_stall(lsu_stall), .lsu_rdata(lsu_rdata),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
  } req_t;

  typedef struct {
    bit          err;
    bit          load;
    logic [31:0] rdata;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t mon_r;
  rsp_t mon_p;
  logic prev_req = 1'b0;

  int total = 0;
  int bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Monitor: checks each new memory request and each completion against the queues.
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (req_q.size() == 0) check1("unexpected_mem_req", mem_req, 1'b0);
      else begin
        mon_r = req_q.pop_front();
        check32("mem_addr", mem_addr, mon_r.addr);
        check1("mem_we", mem_we, mon_r.we);
        check32("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, mon_r.strb});
        if (mon_r.chk_wdata) check32("mem_wdata", mem_wdata, mon_r.wdata);
      end
    end
    prev_req = mem_req;
    if (lsu_done || lsu_err) begin
      if (rsp_q.size() == 0) check1("unexpected_completion", 1'b1, 1'b0);
      else begin
        mon_p = rsp_q.pop_front();
        check1("lsu_err", lsu_err, mon_p.err);
        check1("lsu_done", lsu_done, !mon_p.err);
        if (mon_p.err || mon_p.load) check32("lsu_rdata", lsu_rdata, mon_p.rdata);
      end
    end
  end

  // Reference: decode the request from the instruction-set rules, then drive it and act as memory.
  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int dly);
    bit half, word, mis, trap;
    logic [31:0] ea, v;
    int lane, exp_lat, exp_n, cyc, nreq, nstall;
    bit fin;
    req_t r;
    rsp_t p;
    half = (f3 == 3'd1) || (f3 == 3'd5 && !we);
    word = (f3 == 3'd2);
    mis  = (half && a[0]) || (word && (a % 4 != 0));
    ea   = a;
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
    if (half) ea = a - (a % 2);
    if (word) ea = a - (a % 4);
`endif
    lane = int'(ea % 4);
    if (!trap) begin
      r.we = we;
      r.addr = ea - lane;
      r.strb = 4'd0;
      r.wdata = wd;
      if (we) begin
        if (f3 == 3'd0) begin r.strb = 4'(1 << lane); r.wdata = (wd % 256) * 32'h0101_0101; end
        if (f3 == 3'd1) begin r.strb = 4'(3 << lane); r.wdata = (wd % 65536) * 32'h0001_0001; end
        if (f3 == 3'd2) r.strb = 4'd15;
      end
      r.chk_wdata = we && (r.strb != 0);
      req_q.push_back(r);
    end
    p.load = !we;
    p.rdata = 32'd0;
    if (trap) begin
      p.err = 1'b1; exp_lat = 2; exp_n = 0;
    end else if (dly < 0) begin
      p.err = 1'b1; exp_lat = TO + 2; exp_n = TO;
    end else begin
      p.err = 1'b0; exp_lat = dly + 3; exp_n = dly + 1;
      v = rd >> (8 * lane);
      case (f3)
        3'd0: begin p.rdata = v % 256; if (p.rdata >= 128) p.rdata = p.rdata - 32'd256; end
        3'd1: begin p.rdata = v % 65536; if (p.rdata >= 32768) p.rdata = p.rdata - 32'd65536; end
        3'd2: p.rdata = v;
        3'd4: p.rdata = v % 256;
        3'd5: p.rdata = v % 65536;
        default: p.rdata = 32'd0;
      endcase
    end
    rsp_q.push_back(p);

    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = we; lsu_func3 = f3; lsu_addr = a; lsu_wdata = wd;
    cyc = 0; nreq = 0; nstall = 0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (lsu_stall) nstall++;
      if (mem_req) begin
        nreq++;
        if (dly >= 0 && nreq == dly + 1) begin mem_ack = 1'b1; mem_rdata = rd; end
        else begin mem_ack = 1'b0; mem_rdata = $urandom; end
      end else mem_ack = 1'b0;
      if (lsu_done || lsu_err) fin = 1'b1;
    end
    if (!fin) check1("completion_bound", 1'b0, 1'b1);
    check32("latency", cyc, exp_lat);
    check32("mem_req_cycles", nreq, exp_n);
    check32("stall_cycles", nstall, exp_n + 1);
    @(posedge clk); #1;
    lsu_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got running want finished");
    $fatal(1, "time limit");
  end

  initial begin
    req_t r;
    int d, rr;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_done", lsu_done, 1'b0);
    check1("rst_err", lsu_err, 1'b0);
    check32("rst_rdata", lsu_rdata, 32'd0);
    check32("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check32("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    txn(1'b0, 3'd0, 32'h0000_1003, 32'd0, 32'h8012_3456, 0);
    txn(1'b0, 3'd4, 32'h0000_1003, 32'd0, 32'h8012_3456, 0);
    txn(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 3);
    txn(1'b0, 3'd2, 32'h0000_1000, 32'd0, 32'd0, -1);
    txn(1'b0, 3'd2, 32'h0000_3001, 32'd0, 32'h1122_3344, 0);

    // asynchronous reset in the middle of a store access
    r.we = 1'b1; r.strb = 4'hF; r.addr = 32'h4000; r.wdata = 32'hCAFE_F00D; r.chk_wdata = 1'b1;
    req_q.push_back(r);
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_func3 = 3'd2; lsu_addr = 32'h4000; lsu_wdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    check1("pre_rst_mem_req", mem_req, 1'b1);
    #2;
    rst_n = 1'b0; lsu_req = 1'b0;
    #1;
    check1("async_rst_mem_req", mem_req, 1'b0);
    check1("async_rst_stall", lsu_stall, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    txn(1'b0, 3'd5, 32'h0000_4002, 32'd0, 32'hBEEF_0000, 0);

    // stray ack while idle must be ignored
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h7F7F_7F7F;
    repeat (2) @(posedge clk);
    #1 mem_ack = 1'b0;
    txn(1'b0, 3'd1, 32'h0000_5000, 32'd0, 32'h0000_8001, 2);

    for (int i = 0; i < 40; i++) begin
      rr = $urandom_range(0, 9);
      d = (rr == 9) ? -1 : rr % 5;
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, d);
    end

    repeat (4) @(posedge clk);
    #1;
    check32("queues_drained", req_q.size() + rsp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
